// File: rtl/cnn_pkg.sv
// Shared constants, state type and duplication slot table for the CNN operand loader.
// CNN_DUP_FILL_EN selects the 10-write duplication fill order instead of 14 sequential writes.
package cnn_pkg;

  localparam int NUM_SLOTS  = 14;
  localparam int SLOT_W     = 16;
  localparam int CNT_W      = 4;
  localparam int FRAME_W    = NUM_SLOTS * SLOT_W;
  localparam int DUP_WRITES = 10;

`ifdef CNN_DUP_FILL_EN
  localparam int WRITES_PER_FRAME = DUP_WRITES;
`else
  localparam int WRITES_PER_FRAME = NUM_SLOTS;
`endif

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } fill_state_e;

  // Write number -> primary slot; slots 1, 8, 9 are filled as copies and 11 is never written.
  function automatic int unsigned dup_slot(input logic [CNT_W-1:0] idx);
    case (int'(idx))
      0:       return 0;
      1:       return 2;
      2:       return 3;
      3:       return 4;
      4:       return 5;
      5:       return 6;
      6:       return 7;
      7:       return 10;
      8:       return 12;
      9:       return 13;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/cnn_operand_loader.sv
// Collects 16-bit operand words into a frame buffer and hands the full frame over with valid/ready.
// Build option CNN_DUP_FILL_EN enables the fixed slot-duplication fill map (10 writes per frame).
//
// state | meaning
// FILL  | accepting writes into slot order position fill_cnt
// FULL  | frame complete and frozen, frame_valid high, waiting for frame_ready
module cnn_operand_loader
  import cnn_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [31:0]        wr_data,
  input  logic               frame_ready,
  output logic               frame_valid,
  output logic [FRAME_W-1:0] frame_data,
  output logic [CNT_W-1:0]   fill_cnt,
  output logic               wr_drop
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WRITES_PER_FRAME - 1);

  fill_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic               drop_q, drop_d;
  logic               do_write;
  logic [CNT_W-1:0]   wr_idx;
  logic [15:0]        unused_wr_hi;

  assign unused_wr_hi = wr_data[31:16];

  function automatic int unsigned slot_of(input logic [CNT_W-1:0] idx);
`ifdef CNN_DUP_FILL_EN
    return dup_slot(idx);
`else
    return 32'(idx);
`endif
  endfunction

  function automatic logic [FRAME_W-1:0] store_word(input logic [FRAME_W-1:0] frame,
                                                    input int unsigned      slot,
                                                    input logic [SLOT_W-1:0] word);
    logic [FRAME_W-1:0] f;
    f = frame;
    f[slot*SLOT_W +: SLOT_W] = word;
`ifdef CNN_DUP_FILL_EN
    if (slot == 0) begin
      f[1*SLOT_W +: SLOT_W] = word;
    end
    if (slot == 7) begin
      f[8*SLOT_W +: SLOT_W] = word;
      f[9*SLOT_W +: SLOT_W] = word;
    end
`endif
    return f;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else if (clear) begin
      state_q <= FILL;
      cnt_q   <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    drop_d   = drop_q;
    do_write = 1'b0;
    wr_idx   = cnt_q;

    case (state_q)
      FILL: begin
        if (wr_en) begin
          do_write = 1'b1;
          wr_idx   = cnt_q;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        // A write in the consume cycle starts the next frame with no bubble.
        if (frame_ready) begin
          state_d = FILL;
          cnt_d   = '0;
          if (wr_en) begin
            do_write = 1'b1;
            wr_idx   = '0;
            cnt_d    = CNT_W'(1);
          end
        end else if (wr_en) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase

    if (do_write) begin
      data_d = store_word(data_q, slot_of(wr_idx), wr_data[SLOT_W-1:0]);
    end
  end

  assign frame_valid = (state_q == FULL);
  assign frame_data  = data_q;
  assign fill_cnt    = cnt_q;
  assign wr_drop     = drop_q;

endmodule

// File: doc/cnn_operand_loader.md
Name: cnn_operand_loader

Overview:
Sequential operand collector directly upstream of the ALU's CNN engines (winograd, relu, CNNConvolution). Captures packed 16-bit operand pairs written by the datapath, one word per cycle, into a 14-slot frame buffer. Presents the complete frame with a valid/ready handshake, replacing zero-detect slot filling. Zero-valued operands are legal data.

Parameters:
NUM_SLOTS, 14, number of 16-bit slots per frame (slot k feeds engine operand pair k)
SLOT_W, 16, bits kept per slot: wr_data[15:8] high byte, wr_data[7:0] low byte
CNT_W, 4, width of fill counter; must satisfy 2**CNT_W > NUM_SLOTS

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active low
clear  input  1  synchronous abort: discard partial/complete frame
wr_en  input  1  write strobe, decoded by datapath from ALUControl==3'b100
wr_data  input  32  operand word; only [15:0] stored
frame_ready  input  1  consumer accepts frame (CNN op issue, ALUControl 3'b110/3'b111)
frame_valid  output  1  full frame held and stable
frame_data  output  NUM_SLOTS*SLOT_W  slot k at bits [k*16+15 : k*16]
fill_cnt  output  CNT_W  slots written in current frame (0..NUM_SLOTS)
wr_drop  output  1  sticky: a write was discarded because frame was full

Behaviour:
- Reset (rst==0 at clk edge): state FILL, fill_cnt=0, frame_valid=0, frame_data=0, wr_drop=0. Overrides all inputs, including mid-frame.
- States: FILL, FULL. frame_valid = (state==FULL), registered.
- FILL: wr_en stores wr_data[15:0] into slot fill_cnt, fill_cnt+1. Write to slot NUM_SLOTS-1 -> FULL next cycle (frame_valid rises 1 cycle after last write). frame_ready ignored in FILL.
- FULL: frame_data frozen. frame_valid && frame_ready -> consume: fill_cnt=0, state FILL, frame_data unchanged in storage but frame_valid low.
- FULL with wr_en and no consume: write dropped, wr_drop set; cleared only by rst or clear.
- FULL with wr_en and consume same cycle: consume wins, write lands in slot 0 of new frame, fill_cnt=1 (zero-bubble back-to-back).
- clear: priority below rst, above everything else: fill_cnt=0, state FILL, frame_valid=0, wr_drop=0, frame_data zeroed; concurrent wr_en ignored.
- Slots not yet written in a new frame keep stale values; consumers must only sample on frame_valid.
- No arithmetic beyond counter; fill_cnt never exceeds NUM_SLOTS (saturates, no wrap).

Optional Feature:
CNN_DUP_FILL_EN: when defined, fixed duplication map for the engine's tied operands: write to slot 0 also loads slot 1; write to slot 7 also loads slots 8 and 9; slot 11 is forced to 0 and skipped. Write order 0,2,3,4,5,6,7,10,12,13 (10 writes per frame); frame completes on write to slot 13. fill_cnt reports writes taken (0..10). Without macro: 14 independent sequential writes, no duplication, slot 11 writable.

Decomposition:
- Shared package cnn_pkg: NUM_SLOTS, SLOT_W, state enum (FILL/FULL), slot-order table and write count for dup mode (DUP_WRITES=10).
- No sub-module; next-slot/duplication decode is a local function. Single flat module.

Test Plan:
- Reset then 14 writes of 0x0000_0101*k (k=0..13) -> frame_valid rises cycle after 14th; slot 0==0x0000, slot 13==0x0D0D; fill_cnt==14.
- Full frame, frame_ready held low 5 cycles with wr_en=1, data 0xAAAA -> frame_data unchanged, wr_drop=1; then frame_ready=1 -> frame_valid=0, fill_cnt=0.
- Full frame, frame_ready=1 and wr_en=1 data 0x1234 same cycle -> frame_valid=0, fill_cnt=1, slot 0==0x1234 next cycle.
- 6 writes then clear=1 with wr_en=1 -> fill_cnt=0, frame_data all 0, wr_drop=0; 14 further writes form clean frame.
- rst=0 asserted after 9 writes -> all outputs reset values next edge; rst released, 14 writes -> valid frame.
- CNN_DUP_FILL_EN: 10 writes 0x0102,0x0304,...,0x1314 -> slot1==slot0==0x0102, slots 8,9==slot7 value, slot11==0, frame_valid after 10th write.
